// File: rtl/fft_pkg.sv
// Shared constants and FSM state encoding for the 32-point radix-2 FFT address sequencer.
package fft_pkg;

   localparam int PTS            = 32;
   localparam int LOG2PTS        = $clog2(PTS);
   localparam int BFLY_PER_STAGE = PTS / 2;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      FIN
   } seq_state_e;

endpackage

// File: rtl/fft_wb_delay.sv
// Write-back alignment: a LAT-deep shift register carrying {valid, addr0, addr1}.
module fft_wb_delay #(
   parameter int N   = 5,
   parameter int LAT = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inValid_i,
   input  logic [N-1:0] inAddr0_i,
   input  logic [N-1:0] inAddr1_i,
   output logic         outValid_o,
   output logic [N-1:0] outAddr0_o,
   output logic [N-1:0] outAddr1_o
);

   localparam int W = 2 * N + 1;

   logic [W-1:0] pipe_q [LAT];

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= {inValid_i, inAddr0_i, inAddr1_i};
         for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   // Read addresses are already zero when rd_en is low, so the tap needs no gating.
   assign {outValid_o, outAddr0_o, outAddr1_o} = pipe_q[LAT-1];

endmodule

// File: rtl/fft32_sequencer.sv
// In-place radix-2 FFT address sequencer: issues 16 butterflies per stage, drains the
// datapath latency between stages so no read overtakes a pending write, then pulses done.
module fft32_sequencer
   import fft_pkg::*;
#(
   parameter int N   = LOG2PTS,
   parameter int LAT = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   output logic         busy,
   output logic         done,
   output logic         rd_en,
   output logic [N-1:0] rd_addr0,
   output logic [N-1:0] rd_addr1,
   output logic [N-2:0] tw_idx,
   output logic         wr_en,
   output logic [N-1:0] wr_addr0,
   output logic [N-1:0] wr_addr1,
   output logic [2:0]   stage
);

   localparam int            BFLY       = (N == LOG2PTS) ? BFLY_PER_STAGE : (1 << (N - 1));
   localparam logic [N-2:0]  K_LAST     = (N-1)'(BFLY - 1);
   localparam logic [2:0]    LAST_STAGE = 3'(N - 1);
   localparam logic [3:0]    DRAIN_LAST = 4'(LAT - 1);

   seq_state_e   state_q;
   logic [N-2:0] k_q, nextK_d;
   logic [2:0]   stage_q, nextStage_d;
   logic [3:0]   drainCnt_q;
   logic         busy_q, done_q, rdEn_q;
   logic [N-1:0] rdAddr0_q, rdAddr1_q, addr0_d, addr1_d;
   logic [N-2:0] tw_q, tw_d;

   // Upper operand of butterfly k in stage s: group base (k>>s)*2^(s+1) plus offset k mod 2^s.
   function automatic logic [N-1:0] pairAddr0(input logic [N-2:0] k, input logic [2:0] s);
      logic [N-1:0] kk;
      logic [N-1:0] low;
      kk  = {1'b0, k};
      low = kk & ((N'(1) << s) - N'(1));
      return ((kk >> s) << (s + 3'd1)) | low;
   endfunction

   function automatic logic [N-2:0] twiddleIdx(input logic [N-2:0] k, input logic [2:0] s);
      logic [N-2:0] low;
      low = k & (((N-1)'(1) << s) - (N-1)'(1));
      return low << (3'(N - 1) - s);
   endfunction

   // The butterfly that would be issued at the next edge: first of a transform, first of
   // the next stage after a drain, or the successor within the current stage.
   always_comb begin
      nextK_d     = k_q + 1'b1;
      nextStage_d = stage_q;
      if (state_q == IDLE) begin
         nextK_d     = '0;
         nextStage_d = 3'd0;
      end else if (state_q != ISSUE) begin
         nextK_d     = '0;
         nextStage_d = stage_q + 3'd1;
      end
      addr0_d = pairAddr0(nextK_d, nextStage_d);
      addr1_d = addr0_d + (N'(1) << nextStage_d);
      tw_d    = twiddleIdx(nextK_d, nextStage_d);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         k_q        <= '0;
         stage_q    <= '0;
         drainCnt_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rdEn_q     <= 1'b0;
         rdAddr0_q  <= '0;
         rdAddr1_q  <= '0;
         tw_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q   <= ISSUE;
                  busy_q    <= 1'b1;
                  k_q       <= nextK_d;
                  stage_q   <= nextStage_d;
                  rdEn_q    <= 1'b1;
                  rdAddr0_q <= addr0_d;
                  rdAddr1_q <= addr1_d;
                  tw_q      <= tw_d;
               end
            end
            ISSUE: begin
               if (k_q == K_LAST) begin
                  state_q    <= DRAIN;
                  drainCnt_q <= '0;
                  rdEn_q     <= 1'b0;
                  rdAddr0_q  <= '0;
                  rdAddr1_q  <= '0;
                  tw_q       <= '0;
               end else begin
                  k_q       <= nextK_d;
                  rdAddr0_q <= addr0_d;
                  rdAddr1_q <= addr1_d;
                  tw_q      <= tw_d;
               end
            end
            DRAIN: begin
               // The last write of the stage is on the wire in the final drain cycle.
               if (drainCnt_q == DRAIN_LAST) begin
                  if (stage_q == LAST_STAGE) begin
                     state_q <= FIN;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     stage_q <= '0;
                  end else begin
                     state_q   <= ISSUE;
                     k_q       <= nextK_d;
                     stage_q   <= nextStage_d;
                     rdEn_q    <= 1'b1;
                     rdAddr0_q <= addr0_d;
                     rdAddr1_q <= addr1_d;
                     tw_q      <= tw_d;
                  end
               end else begin
                  drainCnt_q <= drainCnt_q + 4'd1;
               end
            end
            FIN: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   fft_wb_delay #(
      .N   (N),
      .LAT (LAT)
   ) u_wbDelay (
      .clk        (clk),
      .rst        (rst),
      .inValid_i  (rdEn_q),
      .inAddr0_i  (rdAddr0_q),
      .inAddr1_i  (rdAddr1_q),
      .outValid_o (wr_en),
      .outAddr0_o (wr_addr0),
      .outAddr1_o (wr_addr1)
   );

   assign busy     = busy_q;
   assign done     = done_q;
   assign rd_en    = rdEn_q;
   assign rd_addr0 = rdAddr0_q;
   assign rd_addr1 = rdAddr1_q;
   assign tw_idx   = tw_q;
   assign stage    = stage_q;

endmodule

// File: tb/tb_fft32_sequencer.sv
// Bench for fft32_sequencer: three instances (LAT=3,1,8) checked every cycle against a
// cycle-position model of the transform, plus hand-computed address and timing literals.
module tb_fft32_sequencer;

   typedef struct {
      int busy, done, rdEn, wrEn, ra0, ra1, tw, wa0, wa1, stage;
   } exp_t;

   logic       clk = 1'b0;
   logic       rstV [3];
   logic       startV [3];
   logic       busyW [3], doneW [3], rdEnW [3], wrEnW [3];
   logic [4:0] ra0W [3], ra1W [3], wa0W [3], wa1W [3];
   logic [3:0] twW [3];
   logic [2:0] stageW [3];

   int cyc = 0;
   int c [3] = '{-1, -1, -1};
   int startCyc [3] = '{0, 0, 0};
   int tIdx [3] = '{0, 0, 0};
   int prevDone [3] = '{-1000, -1000, -1000};
   int rdCnt [3] = '{0, 0, 0};
   int wrCnt [3] = '{0, 0, 0};
   logic rdPrev [3] = '{1'b0, 1'b0, 1'b0};
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   function automatic int latOf(input int i);
      case (i)
         0:       return 3;
         1:       return 1;
         default: return 8;
      endcase
   endfunction

   // Start-to-done cycle counts worked out by hand for each instance.
   function automatic int durOf(input int i);
      case (i)
         0:       return 96;
         1:       return 86;
         default: return 121;
      endcase
   endfunction

   genvar g;
   for (g = 0; g < 3; g++) begin : gDut
      fft32_sequencer #(.N(5), .LAT(latOf(g))) dut (
         .clk      (clk),
         .rst      (rstV[g]),
         .start    (startV[g]),
         .busy     (busyW[g]),
         .done     (doneW[g]),
         .rd_en    (rdEnW[g]),
         .rd_addr0 (ra0W[g]),
         .rd_addr1 (ra1W[g]),
         .tw_idx   (twW[g]),
         .wr_en    (wrEnW[g]),
         .wr_addr0 (wa0W[g]),
         .wr_addr1 (wa1W[g]),
         .stage    (stageW[g])
      );
   end

   function automatic void pairOf(input int s, input int k, output int a0, output int a1, output int t);
      int span;
      span = 2 ** s;
      a0   = (k / span) * 2 * span + (k % span);
      a1   = a0 + span;
      t    = (k % span) * (16 / span);
   endfunction

   // Expected outputs at position cyc (1 = first cycle after start accepted, -1 = idle).
   function automatic exp_t modelAt(input int lat, input int pos);
      exp_t e;
      int len, last, j, w, ws, dummy;
      e    = '{default: 0};
      len  = 16 + lat;
      last = 5 * len + 1;
      if (pos < 1 || pos > last) return e;
      if (pos == last) begin
         e.done = 1;
         return e;
      end
      e.busy  = 1;
      e.stage = (pos - 1) / len;
      j       = (pos - 1) % len;
      if (j < 16) begin
         e.rdEn = 1;
         pairOf(e.stage, j, e.ra0, e.ra1, e.tw);
      end
      w = pos - lat;
      if (w >= 1) begin
         ws = (w - 1) / len;
         j  = (w - 1) % len;
         if (j < 16) begin
            e.wrEn = 1;
            pairOf(ws, j, e.wa0, e.wa1, dummy);
         end
      end
      return e;
   endfunction

   task automatic checkOutput(input string name, input int idx, input int act, input int want);
      total++;
      if (act !== want) begin
         bad++;
         $display("[TB] FAIL %s dut%0d cyc=%0d got=%0d want=%0d", name, idx, cyc, act, want);
      end
   endtask

   task automatic applyStimulus(input int idx, input logic rstLevel, input logic startLevel);
      rstV[idx]   = rstLevel;
      startV[idx] = startLevel;
   endtask

   // Track where each instance should be inside its transform.
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (!rstV[i]) begin
            c[i] <= -1;
         end else if (c[i] == -1) begin
            if (startV[i]) begin
               c[i]        <= 1;
               startCyc[i] <= cyc;
               tIdx[i]     <= tIdx[i] + 1;
            end
         end else if (c[i] == 5 * (16 + latOf(i)) + 1) begin
            c[i] <= -1;
         end else begin
            c[i] <= c[i] + 1;
         end
      end
      cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         e = modelAt(latOf(i), c[i]);
         checkOutput("busy",     i, int'(busyW[i]),  e.busy);
         checkOutput("done",     i, int'(doneW[i]),  e.done);
         checkOutput("rd_en",    i, int'(rdEnW[i]),  e.rdEn);
         checkOutput("wr_en",    i, int'(wrEnW[i]),  e.wrEn);
         checkOutput("rd_addr0", i, int'(ra0W[i]),   e.ra0);
         checkOutput("rd_addr1", i, int'(ra1W[i]),   e.ra1);
         checkOutput("tw_idx",   i, int'(twW[i]),    e.tw);
         checkOutput("wr_addr0", i, int'(wa0W[i]),   e.wa0);
         checkOutput("wr_addr1", i, int'(wa1W[i]),   e.wa1);
         checkOutput("stage",    i, int'(stageW[i]), e.stage);

         if (c[i] == 1) begin
            rdCnt[i] = 0;
            wrCnt[i] = 0;
         end
         if (rdEnW[i] && !rdPrev[i] && stageW[i] != 3'd0)
            checkOutput("raw_order", i, wrCnt[i], 16 * int'(stageW[i]));
         rdCnt[i]  = rdCnt[i] + int'(rdEnW[i]);
         wrCnt[i]  = wrCnt[i] + int'(wrEnW[i]);
         rdPrev[i] = rdEnW[i];

         if (i == 0 && tIdx[0] == 1) begin
            case (c[0])
               1: begin
                  checkOutput("lit_s0k0_a0", 0, int'(ra0W[0]), 0);
                  checkOutput("lit_s0k0_a1", 0, int'(ra1W[0]), 1);
                  checkOutput("lit_s0k0_tw", 0, int'(twW[0]),  0);
               end
               21: begin
                  checkOutput("lit_s1k1_a0", 0, int'(ra0W[0]), 1);
                  checkOutput("lit_s1k1_a1", 0, int'(ra1W[0]), 3);
                  checkOutput("lit_s1k1_tw", 0, int'(twW[0]),  8);
               end
               92: begin
                  checkOutput("lit_s4k15_a0", 0, int'(ra0W[0]), 15);
                  checkOutput("lit_s4k15_a1", 0, int'(ra1W[0]), 31);
                  checkOutput("lit_s4k15_tw", 0, int'(twW[0]),  15);
               end
               96: begin
                  checkOutput("lit_done96", 0, int'(doneW[0]), 1);
                  checkOutput("lit_busy96", 0, int'(busyW[0]), 0);
               end
               default: ;
            endcase
         end

         if (doneW[i]) begin
            checkOutput("read_count",  i, rdCnt[i], 80);
            checkOutput("write_count", i, wrCnt[i], 80);
            checkOutput("latency",     i, cyc - startCyc[i], durOf(i));
            if (startCyc[i] == prevDone[i] + 1)
               checkOutput("done_period", i, cyc - prevDone[i], durOf(i) + 1);
            prevDone[i] = cyc;
         end
      end
   end

   initial begin
      for (int i = 0; i < 3; i++) applyStimulus(i, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) applyStimulus(i, 1'b1, 1'b0);
      @(negedge clk);

      // Single transform on every instance, with a stray start on dut0 at cycle 40.
      for (int i = 0; i < 3; i++) applyStimulus(i, 1'b1, 1'b1);
      @(negedge clk);
      for (int i = 0; i < 3; i++) applyStimulus(i, 1'b1, 1'b0);
      repeat (39) @(negedge clk);
      applyStimulus(0, 1'b1, 1'b1);
      @(negedge clk);
      applyStimulus(0, 1'b1, 1'b0);
      repeat (90) @(negedge clk);

      // Start held high: back-to-back transforms on dut0.
      applyStimulus(0, 1'b1, 1'b1);
      repeat (300) @(negedge clk);
      applyStimulus(0, 1'b1, 1'b0);
      repeat (110) @(negedge clk);

      // Aborts: dut2 reset in a drain window at cycle 20, dut0 reset at cycle 50.
      applyStimulus(0, 1'b1, 1'b1);
      applyStimulus(2, 1'b1, 1'b1);
      @(negedge clk);
      applyStimulus(0, 1'b1, 1'b0);
      applyStimulus(2, 1'b1, 1'b0);
      repeat (19) @(negedge clk);
      applyStimulus(2, 1'b0, 1'b0);
      @(negedge clk);
      applyStimulus(2, 1'b1, 1'b0);
      repeat (29) @(negedge clk);
      applyStimulus(0, 1'b0, 1'b0);
      @(negedge clk);
      applyStimulus(0, 1'b1, 1'b0);
      repeat (10) @(negedge clk);

      // Clean restart of every instance after the aborts.
      for (int i = 0; i < 3; i++) applyStimulus(i, 1'b1, 1'b1);
      @(negedge clk);
      for (int i = 0; i < 3; i++) applyStimulus(i, 1'b1, 1'b0);
      repeat (130) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
